// File: rtl/sar_result_decimator_if.sv
// Output stream of the SAR result decimator: averaged samples with valid/ready handshake.
interface sar_result_decimator_if #(
    parameter int unsigned N_BITS = 10
);
    logic              out_valid;
    logic              out_ready;
    logic [N_BITS-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/sar_result_decimator.sv
// SAR result decimator: edge-detects eoc, averages 2^OSR_LOG2 results, queues averages in a
// small FIFO and raises sticky overflow / conversion-stall timeout flags.
// Optional macro SAR_DECIM_ROUND_EN: round-half-up averaging (clamped) instead of truncation.
module sar_result_decimator #(
    parameter int unsigned N_BITS         = 10,
    parameter int unsigned OSR_LOG2       = 2,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          eoc,
    input  logic [N_BITS-1:0]             adc_result_digital,
    input  logic                          clear_flags,
    sar_result_decimator_if.master        out_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          timeout
);
    localparam int unsigned AccW = N_BITS + OSR_LOG2 + 1;
    localparam int unsigned CntW = OSR_LOG2 + 1;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CntW-1:0] LastCnt  = CntW'((2 ** OSR_LOG2) - 1);
    localparam logic [WdW-1:0]  WdMax    = WdW'(TIMEOUT_CYCLES);
    localparam logic [LvlW-1:0] FullLvl  = LvlW'(FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e            state_q, state_d;
    logic              eoc_q;
    logic [AccW-1:0]   acc_q, acc_d, acc_next;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WdW-1:0]    wd_q, wd_d;
    logic              run, eoc_rise, push_req, tmo_set;
    logic [N_BITS-1:0] avg;

    logic [N_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]   level_q, level_d;
    logic              pop, push, full, ovf_set;
    logic              overflow_q, timeout_q;

    // Next-state logic; datapath follows the state being entered so an eoc held high through
    // reset with en already high is taken as the first sample.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en)  state_d = StAccum;
            StAccum: if (!en) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        run = (state_d == StAccum);
    end

    // Accumulator, sample counter and watchdog next-state.
    always_comb begin
        eoc_rise = eoc & ~eoc_q;
        acc_next = acc_q + AccW'(adc_result_digital);
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        wd_d     = wd_q;
        push_req = 1'b0;
        tmo_set  = 1'b0;
        if (!run) begin
            acc_d = '0;
            cnt_d = '0;
            wd_d  = '0;
        end else if (eoc_rise) begin
            wd_d = '0;
            if (cnt_q == LastCnt) begin
                push_req = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                acc_d = acc_next;
                cnt_d = cnt_q + 1'b1;
            end
        end else if (wd_q != WdMax) begin
            wd_d    = wd_q + 1'b1;
            tmo_set = (wd_d == WdMax);
        end
    end

`ifdef SAR_DECIM_ROUND_EN
    localparam logic [AccW:0] RoundTerm = (AccW + 1)'((2 ** OSR_LOG2) / 2);
    localparam logic [AccW:0] MaxWide   = (AccW + 1)'((2 ** N_BITS) - 1);
    logic [AccW:0] rounded;

    // Round half up, then clamp to full scale.
    always_comb begin
        rounded = ({1'b0, acc_next} + RoundTerm) >> OSR_LOG2;
        avg     = (rounded > MaxWide) ? '1 : N_BITS'(rounded);
    end
`else
    // Truncating average; the sum of 2^OSR_LOG2 N_BITS values always fits after the shift.
    always_comb begin
        avg = N_BITS'(acc_next >> OSR_LOG2);
    end
`endif

    // FIFO control and sticky flag next-state.
    always_comb begin
        full    = (level_q == FullLvl);
        pop     = (level_q != '0) & out_if.out_ready;
        ovf_set = push_req & full & ~pop;
        push    = push_req & ~ovf_set;
        level_d = level_q + LvlW'(push) - LvlW'(pop);
    end

    // Control state: FSM, edge detector, accumulator, watchdog, pointers and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            eoc_q      <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            wd_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            eoc_q      <= eoc;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
            level_q    <= level_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            // A set in the same cycle as clear_flags wins.
            overflow_q <= (overflow_q & ~clear_flags) | ovf_set;
            timeout_q  <= (timeout_q & ~clear_flags) | tmo_set;
        end
    end

    // FIFO storage; cleared on reset so out_data reads 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= avg;
        end
    end

    assign out_if.out_valid = (level_q != '0);
    assign out_if.out_data  = mem_q[rd_ptr_q];
    assign fifo_level       = level_q;
    assign overflow         = overflow_q;
    assign timeout          = timeout_q;
endmodule

// File: tb/tb_sar_result_decimator.sv
// Bench for sar_result_decimator: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_sar_result_decimator;
    localparam int unsigned NB    = 10;
    localparam int unsigned OSR   = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TO    = 64;
    localparam int          NS    = 1 << OSR;
`ifdef SAR_DECIM_ROUND_EN
    localparam int AvgA = 12;
    localparam int AvgB = 3;
`else
    localparam int AvgA = 11;
    localparam int AvgB = 2;
`endif

    logic                     clk = 1'b0;
    logic                     reset, en, eoc, clear_flags;
    logic [NB-1:0]            adc;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic                     overflow, timeout;

    sar_result_decimator_if #(.N_BITS(NB)) dut_if ();

    sar_result_decimator #(
        .N_BITS(NB), .OSR_LOG2(OSR), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .eoc(eoc), .adc_result_digital(adc),
        .clear_flags(clear_flags), .out_if(dut_if), .fifo_level(fifo_level),
        .overflow(overflow), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int average(input int sum);
`ifdef SAR_DECIM_ROUND_EN
        int v;
        v = (sum + NS / 2) / NS;
        return (v > (1 << NB) - 1) ? (1 << NB) - 1 : v;
`else
        return sum / NS;
`endif
    endfunction

    // Reference model: sums of NS samples into a queue of averages, then compare.
    int m_sum, m_cnt, m_wd;
    int m_q[$];
    bit m_prev, m_ovf, m_tmo;

    always @(posedge clk) begin : model
        bit rise, pop, push, ovf_set, tmo_set;
        int val;
        if (reset) begin
            m_sum = 0; m_cnt = 0; m_wd = 0; m_prev = 0; m_ovf = 0; m_tmo = 0;
            m_q.delete();
        end else begin
            rise = eoc && !m_prev;
            m_prev = eoc;
            pop = (m_q.size() != 0) && dut_if.out_ready;
            push = 0; ovf_set = 0; tmo_set = 0; val = 0;
            if (!en) begin
                m_sum = 0; m_cnt = 0; m_wd = 0;
            end else if (rise) begin
                m_wd = 0;
                m_sum += int'(adc);
                m_cnt++;
                if (m_cnt == NS) begin
                    push = 1; val = average(m_sum); m_sum = 0; m_cnt = 0;
                end
            end else if (m_wd < int'(TO)) begin
                m_wd++;
                if (m_wd == int'(TO)) tmo_set = 1;
            end
            ovf_set = push && (m_q.size() == int'(DEPTH)) && !pop;
            if (pop) void'(m_q.pop_front());
            if (push && !ovf_set) m_q.push_back(val);
            m_ovf = (m_ovf && !clear_flags) || ovf_set;
            m_tmo = (m_tmo && !clear_flags) || tmo_set;
        end
        #1;
        check("valid", int'(dut_if.out_valid), int'(m_q.size() != 0));
        if (m_q.size() != 0) check("data", int'(dut_if.out_data), m_q[0]);
        check("level", int'(fifo_level), m_q.size());
        check("overflow", int'(overflow), int'(m_ovf));
        check("timeout", int'(timeout), int'(m_tmo));
    end

    task automatic pulse(input int v);
        eoc = 1'b1; adc = NB'(v);
        repeat (3) @(negedge clk);
        eoc = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic avg_of(input int v);
        repeat (NS) pulse(v);
    endtask

    task automatic drain(input int exp);
        check("drain_valid", int'(dut_if.out_valid), 1);
        check("drain_data", int'(dut_if.out_data), exp);
        dut_if.out_ready = 1'b1;
        @(negedge clk);
        dut_if.out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; eoc = 1'b1; adc = NB'(10);
        clear_flags = 1'b0; dut_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(dut_if.out_valid), 0);
        check("rst_data", int'(dut_if.out_data), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_timeout", int'(timeout), 0);

        // eoc still high out of reset is sample 1 (10), then 11, 12, 13.
        reset = 1'b0;
        repeat (2) @(negedge clk);
        eoc = 1'b0;
        repeat (2) @(negedge clk);
        pulse(11); pulse(12); pulse(13);
        check("avg_basic_level", int'(fifo_level), 1);
        check("avg_basic_data", int'(dut_if.out_data), AvgA);
        drain(AvgA);
        check("empty_after_drain", int'(fifo_level), 0);

        avg_of(1023);
        check("fullscale", int'(dut_if.out_data), 1023);
        drain(1023);

        // Overflow: five averages into a four-entry FIFO.
        for (int v = 100; v <= 500; v += 100) avg_of(v);
        check("ovf_level", int'(fifo_level), 4);
        check("ovf_flag", int'(overflow), 1);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        check("ovf_cleared", int'(overflow), 0);
        for (int v = 100; v <= 400; v += 100) drain(v);
        check("ovf_drained", int'(fifo_level), 0);

        // Full FIFO with a pop in the same cycle as the push.
        for (int v = 10; v <= 40; v += 10) avg_of(v);
        repeat (NS - 1) pulse(50);
        eoc = 1'b1; adc = NB'(50); dut_if.out_ready = 1'b1;
        @(negedge clk);
        dut_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        eoc = 1'b0;
        repeat (2) @(negedge clk);
        check("pp_level", int'(fifo_level), 4);
        check("pp_overflow", int'(overflow), 0);
        for (int v = 20; v <= 50; v += 10) drain(v);

        // Partial sum discarded when en drops.
        pulse(7); pulse(9);
        en = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b1;
        pulse(1); pulse(2); pulse(3); pulse(4);
        check("discard_level", int'(fifo_level), 1);
        check("discard_data", int'(dut_if.out_data), AvgB);
        drain(AvgB);

        // Watchdog: 64 cycles in ACCUM without an eoc edge.
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        repeat (TO - 1) @(negedge clk);
        check("tmo_before", int'(timeout), 0);
        @(negedge clk);
        check("tmo_at_limit", int'(timeout), 1);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        @(negedge clk);
        check("tmo_cleared_stays", int'(timeout), 0);
        pulse(5);
        check("tmo_after_edge", int'(timeout), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
